// File: rtl/ok_wire_or_pipe_if.sv
// Bus bundle for ok_wire_or_pipe: N channel words in, one merged word plus
// collision status out. The block under test takes the slave view.
interface ok_wire_or_pipe_if #(
  parameter int N = 4,
  parameter int W = 65
);
  logic [N*W-1:0] okEHx;
  logic [N-1:0]   ch_en;
  logic           coll_clr;
  logic [W-1:0]   okEH;
  logic           coll_pulse;
  logic           coll_sticky;
  logic [15:0]    coll_count;
  logic [4:0]     coll_first;

  modport master (
    output okEHx, ch_en, coll_clr,
    input  okEH, coll_pulse, coll_sticky, coll_count, coll_first
  );

  modport slave (
    input  okEHx, ch_en, coll_clr,
    output okEH, coll_pulse, coll_sticky, coll_count, coll_first
  );
endinterface

// File: rtl/ok_wire_or_pipe.sv
// Wired-OR merge of N endpoint buses with a 1- or 2-stage registered OR tree.
// Collisions (two enabled channels driving the same bit in the same cycle)
// travel down a pipeline of equal depth so coll_pulse lines up with the okEH
// word it concerns; sticky flag, saturating count and first offender index
// are updated from that aligned pulse.
module ok_wire_or_pipe #(
  parameter int N      = 4,
  parameter int W      = 65,
  parameter int STAGES = 1,
  parameter int GROUP  = 4
) (
  input logic              okClk,
  input logic              okRst_n,
  ok_wire_or_pipe_if.slave bus
);

  localparam int NG = (N + GROUP - 1) / GROUP;

  logic [W-1:0] m_s      [N];
  logic [W-1:0] pre_s    [0:N-1];
  logic [W-1:0] suf_s    [1:N];
  logic [N-1:0] involved_s;
  logic         coll_s;
  logic [4:0]   idx_s;

  logic [W-1:0] or_next_s;
  logic         pulse_next_s;
  logic [4:0]   idx_next_s;

  logic [W-1:0] okeh_r;
  logic         pulse_r;
  logic [4:0]   idx_r;
  logic         sticky_r;
  logic [15:0]  count_r;
  logic [4:0]   first_r;

  // Mask each channel with its enable in the cycle it is presented.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_s[i] = bus.okEHx[i*W +: W] & {W{bus.ch_en[i]}};
    end
  end

  // Prefix/suffix ORs give, per channel, the OR of every other channel.
  always_comb begin
    pre_s[0] = '0;
    for (int i = 1; i < N; i++) begin
      pre_s[i] = pre_s[i-1] | m_s[i-1];
    end
    suf_s[N] = '0;
    for (int i = N - 1; i >= 1; i--) begin
      suf_s[i] = suf_s[i+1] | m_s[i];
    end
  end

  // A channel is involved when it shares a set bit with any other channel;
  // the lowest involved index wins (scan high to low, last hit kept).
  always_comb begin
    idx_s = 5'd0;
    for (int i = 0; i < N; i++) begin
      involved_s[i] = |(m_s[i] & (pre_s[i] | suf_s[i+1]));
    end
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = involved_s[i] ? 5'(i) : idx_s;
    end
    coll_s = |involved_s;
  end

  generate
    if (STAGES == 2 && NG > 0) begin : g_two
      logic [W-1:0] grp_s [NG];
      logic [W-1:0] grp_r [NG];
      logic         coll_d_r;
      logic [4:0]   idx_d_r;

      // Partial OR over each group of GROUP consecutive channels.
      always_comb begin
        for (int g = 0; g < NG; g++) begin
          grp_s[g] = '0;
        end
        for (int i = 0; i < N; i++) begin
          grp_s[i/GROUP] = grp_s[i/GROUP] | m_s[i];
        end
      end

      // First pipeline stage: group results plus collision info alongside.
      always_ff @(posedge okClk or negedge okRst_n) begin
        if (!okRst_n) begin
          for (int g = 0; g < NG; g++) begin
            grp_r[g] <= '0;
          end
          coll_d_r <= 1'b0;
          idx_d_r  <= 5'd0;
        end else begin
          grp_r    <= grp_s;
          coll_d_r <= coll_s;
          idx_d_r  <= idx_s;
        end
      end

      // Second-stage OR across the registered group results.
      always_comb begin
        or_next_s = '0;
        for (int g = 0; g < NG; g++) begin
          or_next_s = or_next_s | grp_r[g];
        end
        pulse_next_s = coll_d_r;
        idx_next_s   = idx_d_r;
      end
    end else begin : g_one
      // Single stage: the full N-way OR feeds the output register directly.
      always_comb begin
        or_next_s = '0;
        for (int i = 0; i < N; i++) begin
          or_next_s = or_next_s | m_s[i];
        end
        pulse_next_s = coll_s;
        idx_next_s   = idx_s;
      end
    end
  endgenerate

  // Final stage: merged word, aligned collision pulse and its index.
  always_ff @(posedge okClk or negedge okRst_n) begin
    if (!okRst_n) begin
      okeh_r  <= '0;
      pulse_r <= 1'b0;
      idx_r   <= 5'd0;
    end else begin
      okeh_r  <= or_next_s;
      pulse_r <= pulse_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Collision status: a pulse always wins over a clear in the same cycle.
  always_ff @(posedge okClk or negedge okRst_n) begin
    if (!okRst_n) begin
      sticky_r <= 1'b0;
      count_r  <= 16'd0;
      first_r  <= 5'd0;
    end else if (pulse_r) begin
      sticky_r <= 1'b1;
      if (bus.coll_clr) begin
        count_r <= 16'd1;
        first_r <= idx_r;
      end else begin
        count_r <= (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
        first_r <= sticky_r ? first_r : idx_r;
      end
    end else if (bus.coll_clr) begin
      sticky_r <= 1'b0;
      count_r  <= 16'd0;
      first_r  <= 5'd0;
    end else begin
      sticky_r <= sticky_r;
      count_r  <= count_r;
      first_r  <= first_r;
    end
  end

  assign bus.okEH        = okeh_r;
  assign bus.coll_pulse  = pulse_r;
  assign bus.coll_sticky = sticky_r;
  assign bus.coll_count  = count_r;
  assign bus.coll_first  = first_r;

endmodule

// File: tb/tb_ok_wire_or_pipe.sv
// Directed bench for ok_wire_or_pipe: one instance with a single-stage tree,
// one with a two-stage tree (GROUP=2), both fed the same stimulus.
module tb_ok_wire_or_pipe;

  typedef struct packed {
    logic [3:0][64:0] ch;
    logic [3:0]       en;
    logic [64:0]      exp_eh;
    logic             exp_pulse;
    logic [4:0]       exp_first;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs [10];

  ok_wire_or_pipe_if #(.N(4), .W(65)) if1 ();
  ok_wire_or_pipe_if #(.N(4), .W(65)) if2 ();

  ok_wire_or_pipe #(.N(4), .W(65), .STAGES(1), .GROUP(4)) u_dut1 (
    .okClk(clk), .okRst_n(rst_n), .bus(if1)
  );
  ok_wire_or_pipe #(.N(4), .W(65), .STAGES(2), .GROUP(2)) u_dut2 (
    .okClk(clk), .okRst_n(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [64:0] c0, input logic [64:0] c1,
                              input logic [64:0] c2, input logic [64:0] c3,
                              input logic [3:0] en, input logic [64:0] eh,
                              input logic p, input logic [4:0] f);
    vec_t v;
    v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2; v.ch[3] = c3;
    v.en = en; v.exp_eh = eh; v.exp_pulse = p; v.exp_first = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0][64:0] ch, input logic [3:0] en, input logic clr);
    if1.okEHx = ch; if1.ch_en = en; if1.coll_clr = clr;
    if2.okEHx = ch; if2.ch_en = en; if2.coll_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0][64:0] zero_ch;
  logic [3:0][64:0] tmp_ch;

  initial begin
    checks = 0;
    errors = 0;
    zero_ch = '0;

    vecs[0] = mk(65'h1, 65'h0, 65'h100, 65'h0, 4'b1111, 65'h101, 1'b0, 5'd0);
    vecs[1] = mk(65'h0, 65'h3, 65'h0, 65'h2, 4'b1111, 65'h3, 1'b1, 5'd1);
    vecs[2] = mk(65'h0, 65'h3, 65'h0, 65'h2, 4'b0111, 65'h3, 1'b0, 5'd0);
    vecs[3] = mk(65'h1, 65'h0, 65'h1, 65'h0, 4'b1111, 65'h1, 1'b1, 5'd0);
    vecs[4] = mk(65'h0, 65'h0, 65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0005,
                 4'b1111, 65'h1_0000_0000_0000_0005, 1'b1, 5'd2);
    vecs[5] = mk(65'h1, 65'h2, 65'h4, 65'h8, 4'b1111, 65'hF, 1'b0, 5'd0);
    vecs[6] = mk(65'h1FF, 65'h1FF, 65'h1FF, 65'h1FF, 4'b0000, 65'h0, 1'b0, 5'd0);
    vecs[7] = mk(65'h0, 65'h10, 65'h30, 65'h20, 4'b1111, 65'h30, 1'b1, 5'd1);
    vecs[8] = mk(65'hF0, 65'h100, 65'h180, 65'h0, 4'b1111, 65'h1F0, 1'b1, 5'd0);
    vecs[9] = mk(65'hFF, 65'h1, 65'hFF, 65'h2, 4'b1010, 65'h3, 1'b0, 5'd0);

    // Reset state
    rst_n = 1'b0;
    drive(zero_ch, 4'b0000, 1'b0);
    #12;
    check("rst_eh1", if1.okEH, 65'h0);
    check("rst_pulse1", {64'h0, if1.coll_pulse}, 65'h0);
    check("rst_sticky1", {64'h0, if1.coll_sticky}, 65'h0);
    check("rst_count1", {49'h0, if1.coll_count}, 65'h0);
    check("rst_first1", {60'h0, if1.coll_first}, 65'h0);
    check("rst_eh2", if2.okEH, 65'h0);
    check("rst_pulse2", {64'h0, if2.coll_pulse}, 65'h0);
    rst_n = 1'b1;

    // Table: one-cycle vector, check each instance at its own latency
    for (int i = 0; i < 10; i++) begin
      drive(zero_ch, 4'b0000, 1'b1);
      repeat (3) step();
      drive(vecs[i].ch, vecs[i].en, 1'b0);
      step();
      check($sformatf("v%0d_eh1", i), if1.okEH, vecs[i].exp_eh);
      check($sformatf("v%0d_pulse1", i), {64'h0, if1.coll_pulse}, {64'h0, vecs[i].exp_pulse});
      check($sformatf("v%0d_eh2_early", i), if2.okEH, 65'h0);
      drive(zero_ch, 4'b0000, 1'b0);
      step();
      check($sformatf("v%0d_eh1_after", i), if1.okEH, 65'h0);
      check($sformatf("v%0d_sticky1", i), {64'h0, if1.coll_sticky}, {64'h0, vecs[i].exp_pulse});
      check($sformatf("v%0d_count1", i), {49'h0, if1.coll_count}, {64'h0, vecs[i].exp_pulse});
      check($sformatf("v%0d_first1", i), {60'h0, if1.coll_first},
            vecs[i].exp_pulse ? {60'h0, vecs[i].exp_first} : 65'h0);
      check($sformatf("v%0d_eh2", i), if2.okEH, vecs[i].exp_eh);
      check($sformatf("v%0d_pulse2", i), {64'h0, if2.coll_pulse}, {64'h0, vecs[i].exp_pulse});
      step();
      check($sformatf("v%0d_sticky2", i), {64'h0, if2.coll_sticky}, {64'h0, vecs[i].exp_pulse});
      check($sformatf("v%0d_count2", i), {49'h0, if2.coll_count}, {64'h0, vecs[i].exp_pulse});
      check($sformatf("v%0d_first2", i), {60'h0, if2.coll_first},
            vecs[i].exp_pulse ? {60'h0, vecs[i].exp_first} : 65'h0);
    end

    // Clear racing a pulse, first-index hold, plain clear (single-stage DUT)
    drive(zero_ch, 4'b0000, 1'b1);
    repeat (3) step();
    tmp_ch = '0; tmp_ch[1] = 65'h3; tmp_ch[3] = 65'h2;
    drive(tmp_ch, 4'b1111, 1'b0);
    repeat (2) step();
    drive(zero_ch, 4'b0000, 1'b0);
    repeat (2) step();
    check("seq_count2", {49'h0, if1.coll_count}, 65'h2);
    check("seq_first1", {60'h0, if1.coll_first}, 65'h1);
    tmp_ch = '0; tmp_ch[0] = 65'h1; tmp_ch[2] = 65'h1;
    drive(tmp_ch, 4'b1111, 1'b0);
    step();
    check("seq_pulse_clr", {64'h0, if1.coll_pulse}, 65'h1);
    drive(zero_ch, 4'b0000, 1'b1);
    step();
    check("clrwin_sticky", {64'h0, if1.coll_sticky}, 65'h1);
    check("clrwin_count", {49'h0, if1.coll_count}, 65'h1);
    check("clrwin_first", {60'h0, if1.coll_first}, 65'h0);
    tmp_ch = '0; tmp_ch[2] = 65'h4; tmp_ch[3] = 65'h4;
    drive(tmp_ch, 4'b1111, 1'b0);
    step();
    drive(zero_ch, 4'b0000, 1'b0);
    step();
    check("hold_first", {60'h0, if1.coll_first}, 65'h0);
    check("hold_count", {49'h0, if1.coll_count}, 65'h2);
    drive(zero_ch, 4'b0000, 1'b1);
    step();
    drive(zero_ch, 4'b0000, 1'b0);
    check("clr_count", {49'h0, if1.coll_count}, 65'h0);
    check("clr_sticky", {64'h0, if1.coll_sticky}, 65'h0);
    check("clr_first", {60'h0, if1.coll_first}, 65'h0);

    // Saturation of the collision counter
    drive(zero_ch, 4'b0000, 1'b1);
    repeat (3) step();
    tmp_ch = '0; tmp_ch[0] = 65'h1; tmp_ch[1] = 65'h1;
    drive(tmp_ch, 4'b1111, 1'b0);
    repeat (65540) step();
    drive(zero_ch, 4'b0000, 1'b0);
    repeat (3) step();
    check("sat_count1", {49'h0, if1.coll_count}, 65'hFFFF);
    check("sat_count2", {49'h0, if2.coll_count}, 65'hFFFF);
    check("sat_sticky1", {64'h0, if1.coll_sticky}, 65'h1);
    drive(zero_ch, 4'b0000, 1'b1);
    step();
    drive(zero_ch, 4'b0000, 1'b0);
    check("satclr_count1", {49'h0, if1.coll_count}, 65'h0);
    check("satclr_sticky1", {64'h0, if1.coll_sticky}, 65'h0);
    check("satclr_count2", {49'h0, if2.coll_count}, 65'h0);

    // Asynchronous reset with 0x1FF in flight
    tmp_ch = '0; tmp_ch[0] = 65'h1FF; tmp_ch[1] = 65'h1;
    drive(tmp_ch, 4'b1111, 1'b0);
    repeat (3) step();
    check("pre_rst_eh1", if1.okEH, 65'h1FF);
    check("pre_rst_eh2", if2.okEH, 65'h1FF);
    check("pre_rst_count1", {49'h0, if1.coll_count}, 65'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_eh1", if1.okEH, 65'h0);
    check("arst_eh2", if2.okEH, 65'h0);
    check("arst_pulse1", {64'h0, if1.coll_pulse}, 65'h0);
    check("arst_count1", {49'h0, if1.coll_count}, 65'h0);
    check("arst_sticky2", {64'h0, if2.coll_sticky}, 65'h0);
    drive(zero_ch, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_eh1", if1.okEH, 65'h0);
    check("post_rst_eh2", if2.okEH, 65'h0);

    // Latency of the first word after reset release
    tmp_ch = '0; tmp_ch[3] = 65'h5;
    drive(tmp_ch, 4'b1111, 1'b0);
    step();
    drive(zero_ch, 4'b0000, 1'b0);
    check("lat_eh1", if1.okEH, 65'h5);
    check("lat_eh2_early", if2.okEH, 65'h0);
    step();
    check("lat_eh2", if2.okEH, 65'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ok_wire_or_pipe.md
OK_WIRE_OR_PIPE -- requirements
Module: ok_wire_or_pipe

Interface
REQ-001 Parameter N, default 4, number of endpoint channels merged (1..32).
REQ-002 Parameter W, default 65, width of each channel bus.
REQ-003 Parameter STAGES, default 1, register stages in the OR tree (1 or 2).
REQ-004 Parameter GROUP, default 4, channel fan-in of first-stage OR when STAGES=2 (2..8).
REQ-005 okClk  input  1  single clock, all state on rising edge.
REQ-006 okRst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 okEHx  input  N*W  channel buses, channel i at bits [i*W +: W].
REQ-008 ch_en  input  N  per-channel enable; disabled channel contributes all-zero.
REQ-009 coll_clr  input  1  synchronous clear of sticky collision status.
REQ-010 okEH  output  W  registered OR of enabled channels.
REQ-011 coll_pulse  output  1  one-cycle collision indication aligned with okEH.
REQ-012 coll_sticky  output  1  latched collision flag.
REQ-013 coll_count  output  16  saturating count of collision cycles.
REQ-014 coll_first  output  5  lowest channel index involved in first collision since clear.

Function
REQ-015 Masked input m_i = okEHx channel i AND replicated ch_en[i], sampled combinationally in the cycle presented.
REQ-016 okEH SHALL equal OR of all m_i from exactly STAGES cycles earlier; no combinational input-to-output path.
REQ-017 STAGES=1: single register after full N-way OR.
REQ-018 STAGES=2: stage 1 registers OR of each group of GROUP consecutive channels (last group may be partial); stage 2 registers OR of group results.
REQ-019 Collision in a cycle: some bit b and channels i!=j with m_i[b]=m_j[b]=1.
REQ-020 Collision detect and lowest involved index SHALL be delayed through a pipeline of the same depth as the OR tree so coll_pulse aligns with the affected okEH word.
REQ-021 coll_pulse=1 for exactly the cycles whose okEH word derives from a colliding input cycle.
REQ-022 On coll_pulse: coll_sticky<=1; coll_count<=coll_count+1, holding at 16'hFFFF.
REQ-023 coll_first SHALL load the aligned lowest involved index only when coll_pulse=1 and coll_sticky=0 (or clear in same cycle); otherwise hold.
REQ-024 coll_clr=1 without coll_pulse: coll_sticky<=0, coll_count<=0, coll_first<=0 next cycle.
REQ-025 coll_clr and coll_pulse same cycle: collision wins -- coll_sticky=1, coll_count=1, coll_first=new index.
REQ-026 N=1: collision logic constant zero; coll_* outputs remain at reset values.
REQ-027 Changes of ch_en take effect on the input sample of the same cycle; no pipeline flush.
REQ-028 Channel indices wider than needed are zero-extended into coll_first.

Reset
REQ-029 okRst_n low SHALL immediately clear all pipeline registers: okEH=0, coll_pulse=0, coll_sticky=0, coll_count=0, coll_first=0.
REQ-030 Reset mid-stream discards in-flight words; first valid okEH after release appears STAGES cycles after first post-reset sample.
REQ-031 Release of okRst_n is synchronised by the instantiating level; block needs no internal synchroniser.

Verification
REQ-032 N=4,STAGES=1: ch0=0x1, ch2=0x100, all enabled -> okEH=0x101 one cycle later, coll_pulse=0.
REQ-033 N=4,STAGES=2,GROUP=2: ch1=0x3, ch3=0x2 -> okEH=0x3 and coll_pulse=1 two cycles later, coll_first=1, coll_count=1.
REQ-034 Same stimulus with ch_en=4'b0111 -> okEH=0x3, coll_pulse=0, count unchanged.
REQ-035 Force collision 65540 consecutive cycles -> coll_count holds 16'hFFFF; then coll_clr with no collision -> count=0, sticky=0.
REQ-036 coll_clr asserted in cycle of coll_pulse (ch0,ch2 overlap) -> sticky=1, count=1, coll_first=0.
REQ-037 Assert okRst_n low between okClk edges while pipeline holds 0x1FF -> okEH=0 without clock edge; after release idle inputs keep okEH=0.
